layer_scheduler: RTL and testbench

- Sequences per-layer LED data from a double-buffered frame memory into the cube's serial LED controller, one layer at a time.
- Drives the one-hot layer-select (anode) lines with a blanking interval around each layer change, so the previous layer's data never ghosts onto the next.
- Performs host-requested frame-buffer swaps only on frame boundaries.
- Sits between the frame RAM and the controller's led_vals/latch_enable interface.

---
 rtl/cube_pkg.sv | 20 ++
 rtl/layer_scheduler_if.sv | 22 ++
 rtl/blank_timer.sv | 32 +++
 rtl/layer_scheduler.sv | 141 ++++++++++++++
 tb/tb_layer_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cube_pkg.sv
// rtl/cube_pkg.sv - shared state type, default sizes and one-hot decode for the layer scheduler
package cube_pkg;

    localparam int DEF_NUM_LAYERS = 8;
    localparam int DEF_LAYER_W    = 3;
    localparam int MAX_LAYERS     = 64;

    typedef enum logic [2:0] {
        FETCH,
        WAIT_DATA,
        PRESENT,
        BLANK,
        ADVANCE
    } sched_state_t;

    function automatic logic [MAX_LAYERS-1:0] one_hot(input logic [5:0] idx);
        one_hot = {{(MAX_LAYERS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// rtl/layer_scheduler_if.sv - frame-RAM read port and LED-controller data/latch signals
interface layer_scheduler_if
    import cube_pkg::*;
#(
    parameter int LAYER_W = DEF_LAYER_W
);
    logic               mem_rd;
    logic [LAYER_W:0]   mem_addr;
    logic [7:0]         mem_rdata;
    logic [7:0]         led_vals;
    logic               latch_enable;

    modport master (
        output mem_rd, mem_addr, led_vals,
        input  mem_rdata, latch_enable
    );

    modport slave (
        input  mem_rd, mem_addr, led_vals,
        output mem_rdata, latch_enable
    );
endinterface

// File: rtl/blank_timer.sv
// rtl/blank_timer.sv - loadable down-counter that times the blanking interval
module blank_timer #(
    parameter int BLANK_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [BLANK_W-1:0] load_val,
    input  logic               dec,
    output logic               done
);
    logic [BLANK_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - BLANK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - fetches each layer from the frame RAM, presents it to the LED
// controller, and blanks the anode drivers around every layer change
module layer_scheduler
    import cube_pkg::*;
#(
    parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int LAYER_W      = DEF_LAYER_W,
    parameter int BLANK_CYCLES = 16,
    parameter int BLANK_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    layer_scheduler_if.master     bus,
    output logic [NUM_LAYERS-1:0] layer_sel,
    output logic                  blank,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  buf_sel
);
    sched_state_t       state_q, state_d;
    logic [LAYER_W-1:0] fetch_layer_q, fetch_layer_d;
    logic [LAYER_W-1:0] shown_layer_q, shown_layer_d;
    logic [7:0]         led_vals_q, led_vals_d;
    logic               blank_q, blank_d;
    logic               mem_rd_q, mem_rd_d;
    logic [LAYER_W:0]   mem_addr_q, mem_addr_d;
    logic               buf_sel_q, buf_sel_d;
    logic               swap_ack_q, swap_ack_d;
    logic               latch_q, latch_d;
    logic               latch_edge, frame_end;
    logic               tmr_load, tmr_dec, tmr_done;

    assign latch_d    = bus.latch_enable;
    assign latch_edge = bus.latch_enable & ~latch_q;
    assign frame_end  = (fetch_layer_q == LAYER_W'(NUM_LAYERS - 1));

    blank_timer #(.BLANK_W(BLANK_W)) u_blank_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (BLANK_W'(BLANK_CYCLES - 1)),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:     state_d = WAIT_DATA;
            WAIT_DATA: state_d = PRESENT;
            PRESENT:   if (latch_edge) state_d = BLANK;
            BLANK:     if (tmr_done) state_d = ADVANCE;
            ADVANCE:   state_d = FETCH;
            default:   state_d = FETCH;
        endcase
    end

    always_comb begin
        fetch_layer_d = fetch_layer_q;
        shown_layer_d = shown_layer_q;
        led_vals_d    = led_vals_q;
        blank_d       = blank_q;
        mem_addr_d    = mem_addr_q;
        buf_sel_d     = buf_sel_q;
        mem_rd_d      = 1'b0;
        swap_ack_d    = 1'b0;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = {buf_sel_q, fetch_layer_q};
            end
            WAIT_DATA: led_vals_d = bus.mem_rdata;
            PRESENT: begin
                if (latch_edge) begin
                    blank_d  = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            BLANK: begin
                if (tmr_done) begin
                    shown_layer_d = fetch_layer_q;
                    blank_d       = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ADVANCE: begin
                // Power-of-two layer count lets the increment wrap on its own.
                fetch_layer_d = fetch_layer_q + LAYER_W'(1);
                if (frame_end && swap_req) begin
                    buf_sel_d  = ~buf_sel_q;
                    swap_ack_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_layer_q <= '0;
            shown_layer_q <= '0;
            led_vals_q    <= '0;
            blank_q       <= 1'b1;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            buf_sel_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            latch_q       <= 1'b0;
        end else begin
            fetch_layer_q <= fetch_layer_d;
            shown_layer_q <= shown_layer_d;
            led_vals_q    <= led_vals_d;
            blank_q       <= blank_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            buf_sel_q     <= buf_sel_d;
            swap_ack_q    <= swap_ack_d;
            latch_q       <= latch_d;
        end
    end

    // Anodes derive from blank so they can never be lit while blanked, even mid-reset.
    assign layer_sel    = blank_q ? '0 : NUM_LAYERS'(one_hot(6'(shown_layer_q)));
    assign blank        = blank_q;
    assign swap_ack     = swap_ack_q;
    assign buf_sel      = buf_sel_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.led_vals = led_vals_q;
endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - scoreboard bench for layer_scheduler against a layer/frame model
module tb_layer_scheduler;
    import cube_pkg::*;

    localparam int NL = 8;
    localparam int LW = 3;
    localparam int BC = 16;

    typedef struct packed {
        logic [NL-1:0] sel;
        logic [7:0]    vals;
    } disp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NL-1:0] layer_sel;
    logic          blank, swap_req, swap_ack, buf_sel;
    logic [7:0]    ram [16];

    int vectors = 0;
    int miscompares = 0;

    logic [LW:0] addr_q [$];
    disp_t       disp_q [$];
    logic        swap_q [$];

    int   m_layer;
    logic m_buf;
    bit   m_lit;

    always #5 clk = ~clk;

    layer_scheduler_if #(.LAYER_W(LW)) bus ();

    assign bus.mem_rdata = bus.mem_rd ? ram[bus.mem_addr] : 8'h00;

    layer_scheduler #(
        .NUM_LAYERS(NL), .LAYER_W(LW), .BLANK_CYCLES(BC), .BLANK_W(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .layer_sel(layer_sel), .blank(blank),
        .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        bit    prev_blank;
        bit    timing;
        int    run;
        disp_t d;
        prev_blank = 1'b1;
        timing = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_blank = 1'b1;
                timing = 1'b0;
            end else begin
                if (bus.mem_rd) begin
                    if (addr_q.size() == 0) check("unexpected_mem_rd", 32'(bus.mem_rd), 32'd0);
                    else check("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
                end
                if (swap_ack) begin
                    if (swap_q.size() == 0) check("unexpected_swap_ack", 32'(swap_ack), 32'd0);
                    else check("buf_sel_on_swap_ack", 32'(buf_sel), 32'(swap_q.pop_front()));
                end
                check("layer_sel_onehot", 32'($countones(layer_sel)), blank ? 32'd0 : 32'd1);
                if (prev_blank && !blank) begin
                    if (disp_q.size() == 0) begin
                        check("unexpected_unblank", 32'(blank), 32'd1);
                    end else begin
                        d = disp_q.pop_front();
                        check("layer_sel", 32'(layer_sel), 32'(d.sel));
                        check("led_vals_shown", 32'(bus.led_vals), 32'(d.vals));
                    end
                    if (timing) check("blank_cycles", 32'(run), 32'(BC));
                    timing = 1'b0;
                end else if (blank && !prev_blank) begin
                    timing = 1'b1;
                    run = 1;
                end else if (blank && timing) begin
                    run++;
                end
                prev_blank = blank;
            end
        end
    end

    task automatic wait_mem_rd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.mem_rd) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            ok = bus.mem_rd;
            check("mem_rd_timeout", 32'(bus.mem_rd), 32'd1);
        end
    endtask

    task automatic wait_unblank(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!blank) ok = 1'b1;
        end
        if (!ok) check("unblank_timeout", 32'(blank), 32'd0);
    endtask

    // Presents the layer the model expects next; the caller sits in the cycle after unblank.
    task automatic do_layer(input bit sreq, input int gap, input int hold, input bit glitch);
        bit          ok;
        disp_t       d;
        logic [LW:0] idx;
        if (glitch) begin
            @(posedge clk); #1 bus.latch_enable = 1'b1;
            @(posedge clk); #1 bus.latch_enable = 1'b0;
        end
        wait_mem_rd(ok);
        if (!ok) return;
        swap_req = sreq;
        idx = {m_buf, LW'(m_layer)};
        d.sel = NL'(1) << m_layer;
        d.vals = ram[idx];
        disp_q.push_back(d);
        if (m_layer == NL - 1 && sreq) begin
            m_buf = ~m_buf;
            swap_q.push_back(m_buf);
        end
        m_layer = (m_layer + 1) % NL;
        addr_q.push_back({m_buf, LW'(m_layer)});
        @(posedge clk); #1;
        check("led_vals_present", 32'(bus.led_vals), 32'(d.vals));
        for (int i = 0; i <= gap; i++) begin
            check("blank_in_present", 32'(blank), m_lit ? 32'd0 : 32'd1);
            if (i < gap) begin
                @(posedge clk); #1;
            end
        end
        bus.latch_enable = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.latch_enable = 1'b0;
        check("blank_after_edge", 32'(blank), 32'd1);
        wait_unblank(ok);
        m_lit = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blank"}, 32'(blank), 32'd1);
        check({tag, "_layer_sel"}, 32'(layer_sel), 32'd0);
        check({tag, "_led_vals"}, 32'(bus.led_vals), 32'd0);
        check({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
        check({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        check({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
    endtask

    task automatic reset_mid(input bit in_blank);
        bit ok;
        wait_mem_rd(ok);
        @(posedge clk); #1;
        if (in_blank) begin
            bus.latch_enable = 1'b1;
            @(posedge clk); #1 bus.latch_enable = 1'b0;
            repeat (4) @(posedge clk);
            #1 check("blank_before_reset", 32'(blank), 32'd1);
        end
        check("buf_sel_before_reset", 32'(buf_sel), 32'(m_buf));
        #2 reset_n = 1'b0;
        #1 check_reset_outputs(in_blank ? "rst_mid_blank" : "rst_mid_present");
        addr_q.delete();
        disp_q.delete();
        swap_q.delete();
        m_layer = 0;
        m_buf = 1'b0;
        m_lit = 1'b0;
        addr_q.push_back('0);
        swap_req = 1'b0;
        bus.latch_enable = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
        ram[0] = 8'hA5;
        bus.latch_enable = 1'b0;
        swap_req = 1'b0;
        m_layer = 0;
        m_buf = 1'b0;
        m_lit = 1'b0;
        addr_q.push_back('0);
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        reset_n = 1'b1;

        // Frame in buffer 0: long latch hold, ignored FETCH edge, swap requested from layer 3.
        do_layer(1'b0, 2, 5, 1'b0);
        do_layer(1'b0, 6, 1, 1'b1);
        do_layer(1'b0, 0, 1, 1'b0);
        for (int l = 3; l < NL; l++) do_layer(1'b1, $urandom_range(0, 3), $urandom_range(1, 5), 1'b0);
        reset_mid(1'b1);

        // Request raised at layer 2 and withdrawn before the boundary: no swap.
        for (int l = 0; l < NL; l++)
            do_layer((l >= 2 && l <= 5), $urandom_range(0, 3), $urandom_range(1, 5), 1'b0);

        for (int l = 0; l < 2 * NL; l++)
            do_layer(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 5),
                     (l != 0) && ($urandom_range(0, 3) == 0));
        reset_mid(1'b0);

        for (int l = 0; l < 3; l++) do_layer(1'b0, $urandom_range(0, 3), $urandom_range(1, 5), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("disp_q_drained", 32'(disp_q.size()), 32'd0);
        check("swap_q_drained", 32'(swap_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
